layer_act_sequencer: RTL and testbench



---
 rtl/layer_act_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_layer_act_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_act_sequencer.sv
// Purpose : byte-stream front/back end for one fully connected node layer;
//           deserialises N_IN activation bytes onto act_bus, waits for the
//           node pipeline, captures N_OUT node outputs and serialises them.
// Latency : act_bus loads on the last input edge; node_out captured LAT+1
//           edges later, out_valid high from that edge.
// Backpr. : out_ready=0 holds DRAIN indefinitely (act_bus frozen, capture
//           register untouched); in_ready is low outside FILL unless
//           ACT_SEQ_OVERLAP_EN lets the next frame fill during WAIT/DRAIN.
//
// Ports:
//   clk, reset      - single clock; asynchronous active-high reset
//   in_data/in_valid/in_ready     - activation byte stream (first byte -> A0x)
//   act_bus         - 8*N_IN registered activations, [7:0] = A0x
//   node_out        - 8*N_OUT node outputs, [7:0] = N0x
//   out_data/out_valid/out_ready  - node output byte stream (N0x first)
//   busy            - high unless in FILL with an empty fill buffer
//
// Optional feature macro: ACT_SEQ_OVERLAP_EN (fill next frame while the
// current one waits/drains).

module layer_act_sequencer #(
  parameter int N_IN  = 15,
  parameter int N_OUT = 15,
  parameter int LAT   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8*N_IN-1:0]    act_bus,
  input  logic [8*N_OUT-1:0]   node_out,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int IDX_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OIDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int WCNT_W = $clog2(LAT + 2);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_IN - 1);
  localparam logic [OIDX_W-1:0] OIDX_LAST = OIDX_W'(N_OUT - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LAT);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0]    r_idx;
  logic [OIDX_W-1:0]   r_oidx;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [8*N_IN-1:0]   r_fill_buf;
  logic [8*N_IN-1:0]   r_act_bus;
  logic [8*N_OUT-1:0]  r_cap;

  logic                w_in_xfer;
  logic                w_fill_done;
  logic                w_out_xfer;
  logic                w_drain_done;
  logic                w_wait_done;
  logic                w_load;
  logic [8*N_IN-1:0]   w_fill_nxt;

`ifdef ACT_SEQ_OVERLAP_EN
  // Fill buffer holds a complete frame that has not yet reached act_bus.
  logic                r_full;
  logic                w_buf_full;
`endif

  // ---------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------
`ifdef ACT_SEQ_OVERLAP_EN
  // FILL never sees a full buffer: a fill completing in FILL loads at once.
  assign in_ready   = ~reset & ~r_full;
`else
  assign in_ready   = ~reset & (r_state == S_FILL);
`endif
  assign out_valid  = (r_state == S_DRAIN);
  assign out_data   = (r_state == S_DRAIN) ? r_cap[r_oidx*8 +: 8] : 8'h00;

  assign w_in_xfer    = in_valid & in_ready;
  assign w_fill_done  = w_in_xfer & (r_idx == IDX_LAST);
  assign w_out_xfer   = out_valid & out_ready;
  assign w_drain_done = w_out_xfer & (r_oidx == OIDX_LAST);
  assign w_wait_done  = (r_state == S_WAIT) & (r_wcnt == WCNT_LAST);

`ifdef ACT_SEQ_OVERLAP_EN
  // A frame finishing on this very edge counts as full too, so the final
  // drain transfer can load it without an idle cycle.
  assign w_buf_full = r_full | w_fill_done;
  assign busy       = ~((r_state == S_FILL) & (r_idx == '0) & ~r_full);
`else
  assign busy       = ~((r_state == S_FILL) & (r_idx == '0));
`endif

  // Fill buffer including the byte arriving this cycle, so a load on the
  // last transfer copies the complete frame.
  always_comb begin
    w_fill_nxt = r_fill_buf;
    if (w_in_xfer) begin
      w_fill_nxt[r_idx*8 +: 8] = in_data;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_fill_done) begin
          w_state_nxt = S_WAIT;
          w_load      = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_wait_done) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
`ifdef ACT_SEQ_OVERLAP_EN
          if (w_buf_full) begin
            w_state_nxt = S_WAIT;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_FILL;
          end
`else
          w_state_nxt = S_FILL;
`endif
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_oidx     <= '0;
      r_wcnt     <= '0;
      r_fill_buf <= '0;
      r_act_bus  <= '0;
      r_cap      <= '0;
    end else begin
      if (w_in_xfer) begin
        r_fill_buf <= w_fill_nxt;
        r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      // act_bus only moves on a load edge; the wait counter restarts there.
      if (w_load) begin
        r_act_bus <= w_fill_nxt;
        r_wcnt    <= '0;
      end else if ((r_state == S_WAIT) && !w_wait_done) begin
        r_wcnt <= r_wcnt + 1'b1;
      end

      if (w_wait_done) begin
        r_cap <= node_out;
      end

      if (w_out_xfer) begin
        r_oidx <= (r_oidx == OIDX_LAST) ? '0 : r_oidx + 1'b1;
      end
    end
  end

`ifdef ACT_SEQ_OVERLAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (w_load) begin
      r_full <= 1'b0;
    end else if (w_fill_done) begin
      r_full <= 1'b1;
    end
  end
`endif

  assign act_bus = r_act_bus;

endmodule

// File: tb/tb_layer_act_sequencer.sv
module tb_layer_act_sequencer;

  localparam int N_IN  = 15;
  localparam int N_OUT = 15;
  localparam int LAT   = 3;

`ifdef ACT_SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [8*N_IN-1:0]   act_bus;
  logic [8*N_OUT-1:0]  node_out;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  int n_chk;
  int n_err;

  layer_act_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_bus   (act_bus),
    .node_out  (node_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs settle 1 time unit after the edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 15-byte ramp: byte k = base + k.
  function automatic logic [119:0] ramp(input logic [7:0] base);
    logic [119:0] v;
    for (int k = 0; k < 15; k++) v[k*8 +: 8] = base + 8'(k);
    return v;
  endfunction

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    node_out  = ramp(8'hA0);

    // Reset values.
    tick();
    tick();
    check("rst_in_ready",  {127'b0, in_ready},  128'd0);
    check("rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("rst_out_data",  {120'b0, out_data},  128'd0);
    check("rst_act_bus",   {8'b0, act_bus},     128'd0);
    check("rst_busy",      {127'b0, busy},      128'd0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", {127'b0, in_ready}, 128'd1);

    // Frame 1: contiguous 0x01..0x0F.
    send_frame(8'h01);
    check("f1_a0",       {120'b0, act_bus[7:0]},     128'h01);
    check("f1_a14",      {120'b0, act_bus[119:112]}, 128'h0F);
    check("f1_bus",      {8'b0, act_bus},            {8'b0, ramp(8'h01)});
    check("f1_busy",     {127'b0, busy},             128'd1);
    check("f1_in_ready", {127'b0, in_ready},         {127'b0, OVL});

    // Capture must use node_out as present at load+4, not earlier.
    for (int e = 1; e <= LAT; e++) begin
      tick();
      check("f1_wait_ov", {127'b0, out_valid}, 128'd0);
    end
    node_out = ramp(8'h10);
    tick();
    check("f1_ov_rise", {127'b0, out_valid}, 128'd1);
    node_out = ramp(8'hC0);
    out_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      check("f1_out", {120'b0, out_data}, 128'(8'h10 + 8'(k)));
      tick();
    end
    out_ready = 1'b0;
    check("f1_done_ov",   {127'b0, out_valid}, 128'd0);
    check("f1_done_busy", {127'b0, busy},      128'd0);
    check("f1_done_rdy",  {127'b0, in_ready},  128'd1);

    // Frame 2: gapped input, junk driven in the gaps.
    node_out = ramp(8'h40);
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h21 + 8'(i);
      tick();
      if (i == N_IN - 2) check("f2_no_early_load", {8'b0, act_bus}, {8'b0, ramp(8'h01)});
      if (i < N_IN - 1) begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
        tick();
      end
    end
    in_valid = 1'b0;
    check("f2_bus", {8'b0, act_bus}, {8'b0, ramp(8'h21)});
    for (int e = 0; e <= LAT; e++) tick();
    check("f2_ov_rise", {127'b0, out_valid}, 128'd1);

    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("f2_out_a", {120'b0, out_data}, 128'(8'h40 + 8'(k)));
      tick();
    end
    // Stall at slot 5; node_out and input activity must not disturb anything.
    out_ready = 1'b0;
    node_out  = ramp(8'hE0);
`ifndef ACT_SEQ_OVERLAP_EN
    in_valid  = 1'b1;
    in_data   = 8'hEE;
`endif
    for (int c = 0; c < 10; c++) begin
      check("stall_data", {120'b0, out_data},  128'h45);
      check("stall_ov",   {127'b0, out_valid}, 128'd1);
      check("stall_bus",  {8'b0, act_bus},     {8'b0, ramp(8'h21)});
      if (!OVL) check("stall_in_ready", {127'b0, in_ready}, 128'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 5; k < N_OUT; k++) begin
      check("f2_out_b", {120'b0, out_data}, 128'(8'h40 + 8'(k)));
      tick();
    end
    out_ready = 1'b0;
    check("f2_done_ov",   {127'b0, out_valid}, 128'd0);
    check("f2_done_busy", {127'b0, busy},      128'd0);

    // Reset after 7 accepted bytes.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h51 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("part_busy", {127'b0, busy}, 128'd1);
    reset = 1'b1;
    #2;
    check("mid_rst_in_ready",  {127'b0, in_ready},  128'd0);
    check("mid_rst_out_valid", {127'b0, out_valid}, 128'd0);
    check("mid_rst_out_data",  {120'b0, out_data},  128'd0);
    check("mid_rst_act_bus",   {8'b0, act_bus},     128'd0);
    check("mid_rst_busy",      {127'b0, busy},      128'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rel_in_ready", {127'b0, in_ready}, 128'd1);
    send_frame(8'h61);
    check("f3_a0",  {120'b0, act_bus[7:0]}, 128'h61);
    check("f3_bus", {8'b0, act_bus},        {8'b0, ramp(8'h61)});

    node_out  = ramp(8'h80);
    out_ready = 1'b1;
`ifdef ACT_SEQ_OVERLAP_EN
    // Next frame streams in during WAIT and DRAIN of this one.
    for (int c = 1; c <= LAT + 1 + N_OUT; c++) begin
      in_valid = (c <= N_IN);
      in_data  = 8'h70 + 8'(c);
      if (c <= LAT + 1) check("ovl_wait_rdy", {127'b0, in_ready}, 128'd1);
      if (c == N_IN + 1) check("ovl_full_rdy", {127'b0, in_ready}, 128'd0);
      if (c > LAT + 1) check("ovl_out", {120'b0, out_data}, 128'(8'h80 + 8'(c - LAT - 2)));
      tick();
    end
    in_valid = 1'b0;
    check("ovl_load_bus", {8'b0, act_bus},     {8'b0, ramp(8'h71)});
    check("ovl_load_ov",  {127'b0, out_valid}, 128'd0);
    node_out = ramp(8'h90);
`endif
    for (int e = 0; e <= LAT; e++) tick();
    check("f3_ov_rise", {127'b0, out_valid}, 128'd1);
    for (int k = 0; k < N_OUT; k++) begin
      check("f3_out", {120'b0, out_data}, 128'(node_out[k*8 +: 8]));
      tick();
    end
    out_ready = 1'b0;
    check("f3_done_ov",   {127'b0, out_valid}, 128'd0);
    check("f3_done_busy", {127'b0, busy},      128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
